// File: rtl/flow_token_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : flow_token_sched_if
// Brief    : Valid/ready byte-keep stream bundle used on both sides of the
//            token-bucket scheduler.
// Revision : 1.0
// ============================================================================
interface flow_token_sched_if #(
    parameter int DATA_WIDTH = 128
);
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] keep;
    logic                    valid;
    logic                    ready;
    logic                    last;

    modport master (output data, keep, valid, last, input ready);
    modport slave  (input data, keep, valid, last, output ready);
endinterface
`default_nettype wire

// File: rtl/flow_token_sched.sv
`default_nettype none
// ============================================================================
// Module   : flow_token_sched
// Brief    : Byte-credit token-bucket scheduler admitting whole frames, with
//            received/sent frame counters and wrap multipliers.
// Revision : 1.0
// ============================================================================
module flow_token_sched #(
    parameter     SIM_MODE            = "TRUE",
    parameter int REG_DATA_WIDTH      = 32,
    parameter int PORT_MNG_DATA_WIDTH = 128,
    parameter int TICK_CYCLES         = 800,
    parameter int BUCKET_MAX          = 16384,
    parameter int MIN_CREDIT          = 64
) (
    input  wire logic                      i_sys_clk,
    input  wire logic                      i_sys_rst,
    input  wire logic [REG_DATA_WIDTH-1:0] i_port_rate,
    input  wire logic [REG_DATA_WIDTH-1:0] i_flow_ctrl_select,
    input  wire logic                      i_clr_cnt,
    output logic [31:0]                    o_recive_package,
    output logic [31:0]                    o_recive_package_multi,
    output logic [31:0]                    o_send_package,
    output logic [31:0]                    o_send_package_multi,
    output logic [23:0]                    o_tokens,
    flow_token_sched_if.slave              s_flow,
    flow_token_sched_if.master             m_flow
);

    localparam int c_keep_w = PORT_MNG_DATA_WIDTH / 8;
    localparam int c_pop_w  = $clog2(c_keep_w + 1);
    localparam int c_tick_w = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    localparam logic [c_tick_w-1:0]  c_tick_last  = c_tick_w'(TICK_CYCLES - 1);
    localparam logic [31:0]          c_cnt_wrap   = (SIM_MODE == "TRUE") ? 32'd255 : 32'hFFFF_FFFF;
    localparam logic signed [23:0]   c_min_credit = 24'(MIN_CREDIT);
    localparam logic signed [25:0]   c_tok_max    = 26'(BUCKET_MAX);
    localparam logic signed [25:0]   c_tok_min    = -26'sd8388608;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FRAME = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic signed [23:0]    r_tokens;
    logic [c_tick_w-1:0]   r_tick_cnt;
    logic                  r_counted;
    logic [31:0]           r_recv;
    logic [31:0]           r_recv_multi;
    logic [31:0]           r_send;
    logic [31:0]           r_send_multi;

    logic                  w_gate;
    logic                  w_acc;
    logic                  w_tick;
    logic                  w_recv_inc;
    logic                  w_send_inc;
    logic                  w_counted_next;
    logic [c_pop_w-1:0]    w_popcnt;
    logic signed [25:0]    w_base;
    logic signed [25:0]    w_inc;
    logic signed [25:0]    w_debit;
    logic signed [25:0]    w_sum;
    logic signed [25:0]    w_tok_next;
    logic                  w_unused;

    // Only the low two bits of each rate/select register carry meaning.
    assign w_unused = ^{i_port_rate[REG_DATA_WIDTH-1:2], i_flow_ctrl_select[REG_DATA_WIDTH-1:2]};

    // Once a frame has begun the gate is held open until its last beat.
    assign w_gate = (r_state == S_FRAME) || (r_tokens >= c_min_credit);
    assign w_acc  = s_flow.valid & m_flow.ready & w_gate;
    assign w_tick = (r_tick_cnt == c_tick_last);

    assign m_flow.data  = s_flow.data;
    assign m_flow.keep  = s_flow.keep;
    assign m_flow.last  = s_flow.last;
    assign m_flow.valid = s_flow.valid & w_gate;
    assign s_flow.ready = m_flow.ready & w_gate;

    assign w_recv_inc = s_flow.valid & (r_state == S_IDLE) & ~r_counted;
    assign w_send_inc = w_acc & s_flow.last;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_acc && !s_flow.last) w_state_next = S_FRAME;
            S_FRAME: if (w_acc && s_flow.last)  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < c_keep_w; i++) begin
            w_popcnt = w_popcnt + c_pop_w'(s_flow.keep[i]);
        end
    end

    always_comb begin
        w_base = 26'sd0;
        case (i_port_rate[1:0])
            2'd0:    w_base = 26'sd100;
            2'd1:    w_base = 26'sd1000;
            2'd2:    w_base = 26'sd2500;
            default: w_base = 26'sd10000;
        endcase
        w_inc = 26'sd0;
        case (i_flow_ctrl_select[1:0])
            2'd0:    w_inc = w_base;
            2'd1:    w_inc = w_base >>> 1;
            2'd2:    w_inc = w_base >>> 2;
            default: w_inc = 26'sd0;
        endcase
    end

    // Refill and debit land in the same cycle; result clamps to the bucket range.
    always_comb begin
        w_debit = w_acc ? $signed(26'(w_popcnt)) : 26'sd0;
        w_sum   = $signed({{2{r_tokens[23]}}, r_tokens}) + (w_tick ? w_inc : 26'sd0) - w_debit;
        if (w_sum > c_tok_max) begin
            w_tok_next = c_tok_max;
        end else if (w_sum < c_tok_min) begin
            w_tok_next = c_tok_min;
        end else begin
            w_tok_next = w_sum;
        end
    end

    always_comb begin
        w_counted_next = r_counted;
        if (w_recv_inc) w_counted_next = 1'b1;
        if (w_send_inc) w_counted_next = 1'b0;
    end

    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rst) begin
            r_state    <= S_IDLE;
            r_tokens   <= c_tok_max[23:0];
            r_tick_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_tokens   <= w_tok_next[23:0];
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + c_tick_w'(1);
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rst) begin
            r_counted    <= 1'b0;
            r_recv       <= '0;
            r_recv_multi <= '0;
            r_send       <= '0;
            r_send_multi <= '0;
        end else begin
            r_counted <= w_counted_next;
            if (i_clr_cnt) begin
                r_recv       <= '0;
                r_recv_multi <= '0;
                r_send       <= '0;
                r_send_multi <= '0;
            end else begin
                if (w_recv_inc) begin
                    if (r_recv == c_cnt_wrap) begin
                        r_recv       <= '0;
                        r_recv_multi <= r_recv_multi + 32'd1;
                    end else begin
                        r_recv <= r_recv + 32'd1;
                    end
                end
                if (w_send_inc) begin
                    if (r_send == c_cnt_wrap) begin
                        r_send       <= '0;
                        r_send_multi <= r_send_multi + 32'd1;
                    end else begin
                        r_send <= r_send + 32'd1;
                    end
                end
            end
        end
    end

    assign o_recive_package       = r_recv;
    assign o_recive_package_multi = r_recv_multi;
    assign o_send_package         = r_send;
    assign o_send_package_multi   = r_send_multi;
    assign o_tokens               = r_tokens;

endmodule
`default_nettype wire

// File: tb/tb_flow_token_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_flow_token_sched
// Brief    : Directed self-checking bench for the token-bucket frame scheduler.
// Revision : 1.0
// ============================================================================
module tb_flow_token_sched;

    logic        clk;
    logic        rst_n;
    logic [31:0] port_rate;
    logic [31:0] flow_sel;
    logic        clr_cnt;
    logic [31:0] recv;
    logic [31:0] recv_multi;
    logic [31:0] send;
    logic [31:0] send_multi;
    logic [23:0] tokens;

    int checks   = 0;
    int failures = 0;
    int beat_id  = 0;

    flow_token_sched_if #(.DATA_WIDTH(128)) s_if ();
    flow_token_sched_if #(.DATA_WIDTH(128)) m_if ();

    flow_token_sched u_dut (
        .i_sys_clk              (clk),
        .i_sys_rst              (rst_n),
        .i_port_rate            (port_rate),
        .i_flow_ctrl_select     (flow_sel),
        .i_clr_cnt              (clr_cnt),
        .o_recive_package       (recv),
        .o_recive_package_multi (recv_multi),
        .o_send_package         (send),
        .o_send_package_multi   (send_multi),
        .o_tokens               (tokens),
        .s_flow                 (s_if),
        .m_flow                 (m_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input int nbytes, input bit is_last, output bit ok);
        int w;
        s_if.valid = 1'b1;
        s_if.last  = is_last;
        s_if.keep  = 16'((64'd1 << nbytes) - 64'd1);
        s_if.data  = {4{32'(beat_id)}};
        beat_id++;
        #1;
        w = 0;
        while (!(m_if.valid && m_if.ready) && w < 2000) begin
            @(negedge clk);
            #1;
            w++;
        end
        ok = (w < 2000);
        @(negedge clk);
        s_if.valid = 1'b0;
        s_if.last  = 1'b0;
    endtask

    task automatic send_frame(input int nbeats, input int last_bytes, output bit ok);
        bit b_ok;
        ok = 1'b1;
        for (int b = 0; b < nbeats; b++) begin
            send_beat((b == nbeats - 1) ? last_bytes : 16, (b == nbeats - 1), b_ok);
            ok = ok & b_ok;
        end
    endtask

    task automatic wait_tick(output bit ok);
        logic [23:0] t0;
        t0 = tokens;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tokens != t0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        bit all_ok;
        bit admitted;
        int ticks;
        logic [23:0] tp;

        rst_n       = 1'b0;
        port_rate   = 32'd0;
        flow_sel    = 32'd3;
        clr_cnt     = 1'b0;
        s_if.valid  = 1'b0;
        s_if.last   = 1'b0;
        s_if.keep   = '0;
        s_if.data   = '0;
        m_if.ready  = 1'b1;

        // Reset state and pass-through
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_tokens", $signed(tokens), 16384);
        check("rst_recv", recv, 0);
        check("rst_recv_multi", recv_multi, 0);
        check("rst_send", send, 0);
        check("rst_send_multi", send_multi, 0);
        check("rst_ready_hi", s_if.ready, 1);
        m_if.ready = 1'b0;
        #1;
        check("rst_ready_lo", s_if.ready, 0);
        m_if.ready = 1'b1;
        s_if.data  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        s_if.keep  = 16'h00F0;
        s_if.last  = 1'b1;
        #1;
        check("pass_data_lo", m_if.data[63:0], 64'hFEDC_BA98_7654_3210);
        check("pass_keep", m_if.keep, 16'h00F0);
        check("pass_last", m_if.last, 1);
        check("pass_valid_idle", m_if.valid, 0);
        s_if.last = 1'b0;
        @(negedge clk);

        // Drain the full bucket with 256 x 64-byte frames, no refill
        all_ok = 1'b1;
        for (int f = 0; f < 256; f++) begin
            send_frame(4, 16, ok);
            all_ok = all_ok & ok;
        end
        check("drain_done", all_ok, 1);
        check("drain_tokens", $signed(tokens), 0);
        s_if.valid = 1'b1;
        s_if.keep  = 16'hFFFF;
        s_if.last  = 1'b0;
        #1;
        check("blk_valid", m_if.valid, 0);
        check("blk_ready", s_if.ready, 0);
        @(negedge clk);
        s_if.valid = 1'b0;
        check("drain_send", send, 0);
        check("drain_send_multi", send_multi, 1);
        check("drain_recv", recv, 1);
        check("drain_recv_multi", recv_multi, 1);

        // Long frame drives the bucket negative, then 15 ticks of refill
        port_rate = 32'd0;
        flow_sel  = 32'd0;
        wait_tick(ok);
        check("t3_tick", ok, 1);
        check("t3_refill", $signed(tokens), 100);
        flow_sel = 32'd3;
        send_frame(3, 4, ok);
        check("t3_to64", $signed(tokens), 64);
        send_frame(94, 12, ok);
        check("t3_long_ok", ok, 1);
        check("t3_neg", $signed(tokens), -1436);
        check("t3_send", send, 2);
        flow_sel   = 32'd0;
        s_if.valid = 1'b1;
        s_if.last  = 1'b0;
        s_if.keep  = 16'hFFFF;
        ticks      = 0;
        admitted   = 1'b0;
        tp         = tokens;
        for (int i = 0; i < 13000; i++) begin
            #1;
            if (m_if.valid) begin
                admitted = 1'b1;
                break;
            end
            @(negedge clk);
            if (tokens != tp) begin
                ticks++;
                tp = tokens;
            end
        end
        check("t3_admitted", admitted, 1);
        check("t3_ticks", ticks, 15);
        check("t3_tokens_at_admit", $signed(tokens), 64);
        flow_sel = 32'd3;
        send_frame(4, 16, ok);
        check("t3_after", $signed(tokens), 0);

        // Downstream stall mid-frame while the bucket is below the start threshold
        flow_sel = 32'd0;
        wait_tick(ok);
        check("t4_tick", ok, 1);
        flow_sel = 32'd3;
        for (int b = 0; b < 3; b++) send_beat(16, 1'b0, ok);
        check("t4_mid_tokens", $signed(tokens), 52);
        m_if.ready = 1'b0;
        s_if.valid = 1'b1;
        s_if.last  = 1'b1;
        s_if.keep  = 16'hFFFF;
        #1;
        check("t4_stall_ready", s_if.ready, 0);
        check("t4_stall_valid", m_if.valid, 1);
        repeat (10) @(negedge clk);
        #1;
        check("t4_stall_tokens", $signed(tokens), 52);
        check("t4_stall_frame", m_if.valid, 1);
        m_if.ready = 1'b1;
        send_beat(16, 1'b1, ok);
        check("t4_resume", $signed(tokens), 36);
        s_if.valid = 1'b1;
        s_if.last  = 1'b0;
        #1;
        check("t4_next_blk", m_if.valid, 0);
        @(negedge clk);
        s_if.valid = 1'b0;

        // Tick and debit in the same cycle
        port_rate = 32'd1;
        flow_sel  = 32'd1;
        wait_tick(ok);
        check("t6_tick", ok, 1);
        check("t6_base", $signed(tokens), 536);
        repeat (799) @(negedge clk);
        s_if.valid = 1'b1;
        s_if.last  = 1'b1;
        s_if.keep  = 16'hFFFF;
        #1;
        check("t6_gate", m_if.valid, 1);
        @(negedge clk);
        s_if.valid = 1'b0;
        s_if.last  = 1'b0;
        check("t6_both", $signed(tokens), 1020);

        // Counter wrap, clear, saturation, clear priority
        port_rate = 32'd3;
        flow_sel  = 32'd0;
        clr_cnt   = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        check("t5_clr0_send", send, 0);
        check("t5_clr0_recv_multi", recv_multi, 0);
        wait_tick(ok);
        check("t5_tick", ok, 1);
        all_ok = 1'b1;
        for (int f = 0; f < 256; f++) begin
            send_beat(16, 1'b1, ok);
            all_ok = all_ok & ok;
        end
        check("t5_sent", all_ok, 1);
        check("t5_send", send, 0);
        check("t5_send_multi", send_multi, 1);
        check("t5_recv", recv, 0);
        check("t5_recv_multi", recv_multi, 1);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        check("t5_clr_send", send, 0);
        check("t5_clr_send_multi", send_multi, 0);
        check("t5_clr_recv", recv, 0);
        check("t5_clr_recv_multi", recv_multi, 0);
        repeat (2000) @(negedge clk);
        check("sat_max", $signed(tokens), 16384);
        s_if.valid = 1'b1;
        s_if.last  = 1'b1;
        s_if.keep  = 16'hFFFF;
        clr_cnt    = 1'b1;
        @(negedge clk);
        clr_cnt    = 1'b0;
        s_if.valid = 1'b0;
        s_if.last  = 1'b0;
        check("clr_prio_send", send, 0);
        check("clr_prio_recv", recv, 0);
        check("clr_prio_tokens", $signed(tokens), 16368);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
